// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide unit.
//
// A radix-2 shift-add multiplier and a restoring divider share one
// (WIDTH+1)-bit add/sub. Operands are converted to magnitudes up front and
// the signs are put back at the end. Latency is WIDTH+3 cycles from the
// accepting edge to the done pulse.
//
// Optional build macro: MDU_EARLY_OUT_EN
//   When defined, divide-by-zero, signed overflow and multiplies with a zero
//   operand skip the iteration phase (done in cycle 3). Results are the same
//   in both builds.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   request, accepted only when idle
//   flush   abort the current operation; no done, result unchanged
//   funct3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//           100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a, b    rs1 / rs2 operands, sampled on the accepting edge
//   busy    high from the cycle after accept through the done cycle
//   done    one-cycle pulse, result valid in the same cycle
//   result  registered result, changes only when done is raised
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]       f_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] opnd;      // multiplicand |a| or divisor |b|
    logic [WIDTH-1:0] acc_lo;    // multiplier / quotient
    logic [WIDTH:0]   acc_hi;    // partial product / partial remainder
    logic [CW-1:0]    cnt;
    logic             sign_a, sign_b;

    // operand decode
    logic             is_div, a_signed, b_signed, neg_a_in, neg_b_in;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             a_zero, b_zero, ovf, mul_zero;

    // shared adder
    logic [WIDTH:0]   div_shift, op_x, op_y, addsub, mul_hi;

    // sign fix-up and output select
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   rem_raw, quo_fix, rem_fix, fix_res;

    always_comb begin
        is_div   = f_q[2];
        a_signed = is_div ? ~f_q[0] : (f_q[1:0] != 2'b11);
        b_signed = is_div ? ~f_q[0] : ~f_q[1];
        neg_a_in = a_signed & a_q[WIDTH-1];
        neg_b_in = b_signed & b_q[WIDTH-1];
        abs_a    = neg_a_in ? -a_q : a_q;
        abs_b    = neg_b_in ? -b_q : b_q;
        a_zero   = (a_q == '0);
        b_zero   = (b_q == '0);
        ovf      = is_div & ~f_q[0] & (a_q == MIN_VAL) & (b_q == '1);
        mul_zero = ~is_div & (a_zero | b_zero);
    end

    // One (WIDTH+1)-bit adder: add for multiply, subtract for divide.
    always_comb begin
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        op_x      = is_div ? div_shift : acc_hi;
        op_y      = {1'b0, opnd};
        addsub    = op_x + (is_div ? ~op_y : op_y) + {{WIDTH{1'b0}}, is_div};
        mul_hi    = acc_lo[0] ? addsub : acc_hi;
    end

    always_comb begin
        prod_raw = {acc_hi[WIDTH-1:0], acc_lo};
        prod_fix = (sign_a ^ sign_b) ? -prod_raw : prod_raw;
        rem_raw  = acc_hi[WIDTH-1:0];
        quo_fix  = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
        rem_fix  = sign_a ? -rem_raw : rem_raw;
        fix_res  = '0;
        case (f_q)
            3'b000:                 fix_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: begin
                if (b_zero)   fix_res = '1;
                else if (ovf) fix_res = a_q;
                else          fix_res = quo_fix;
            end
            default: begin
                if (b_zero)   fix_res = a_q;
                else if (ovf) fix_res = '0;
                else          fix_res = rem_fix;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE: if (start && !flush) state_nxt = S_PREP;
            S_PREP: begin
                if (flush) state_nxt = S_IDLE;
                else begin
`ifdef MDU_EARLY_OUT_EN
                    if ((is_div && (b_zero || ovf)) || mul_zero) state_nxt = S_FIX;
                    else                                         state_nxt = S_CALC;
`else
                    state_nxt = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (flush)                   state_nxt = S_IDLE;
                else if (cnt == CW'(1))      state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = flush ? S_IDLE : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            opnd   <= '0;
            acc_lo <= '0;
            acc_hi <= '0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        a_q <= a;
                        b_q <= b;
                        f_q <= funct3;
                    end
                end
                S_PREP: begin
                    sign_a <= neg_a_in;
                    sign_b <= neg_b_in;
                    acc_hi <= '0;
                    cnt    <= CW'(WIDTH);
                    if (is_div) begin
                        opnd   <= abs_b;
                        acc_lo <= abs_a;
                    end else begin
                        // Zero multiplier forces a zero product even when the
                        // iterations are skipped.
                        opnd   <= abs_a;
                        acc_lo <= mul_zero ? '0 : abs_b;
                    end
                end
                S_CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        // trial non-negative when the borrow bit is clear
                        if (addsub[WIDTH]) acc_hi <= div_shift;
                        else               acc_hi <= addsub;
                        acc_lo <= {acc_lo[WIDTH-2:0], ~addsub[WIDTH]};
                    end else begin
                        acc_hi <= {1'b0, mul_hi[WIDTH:1]};
                        acc_lo <= {mul_hi[0], acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!flush) result <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

    localparam int W = 32;
`ifdef MDU_EARLY_OUT_EN
    localparam int LAT_SP = 3;
`else
    localparam int LAT_SP = 35;
`endif
    localparam int LAT = 35;

    logic          clk, rst_n, start, flush, busy, done;
    logic [2:0]    funct3;
    logic [W-1:0]  a, b, result;

    mdu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .funct3(funct3), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference arithmetic from the instruction definitions.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        logic [31:0] r;
        sa = av;
        sb = bv;
        r  = '0;
        case (f)
            3'd0: begin up = {32'b0, av} * {32'b0, bv}; r = up[31:0]; end
            3'd1: begin sp = longint'(sa) * longint'(sb); r = sp[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'b0, bv}); r = sp[63:32]; end
            3'd3: begin up = {32'b0, av} * {32'b0, bv}; r = up[63:32]; end
            3'd4: begin
                if (bv == 0) r = 32'hFFFF_FFFF;
                else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) r = av;
                else r = sa / sb;
            end
            3'd5: r = (bv == 0) ? 32'hFFFF_FFFF : av / bv;
            3'd6: begin
                if (bv == 0) r = av;
                else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) r = 0;
                else r = sa % sb;
            end
            default: r = (bv == 0) ? av : av % bv;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
        bit sp;
        if (f[2]) sp = (bv == 0) || (!f[0] && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF);
        else      sp = (av == 0) || (bv == 0);
        return sp ? LAT_SP : LAT;
    endfunction

    // Timing/result model: cycles counted since the accepting edge.
    bit          m_active;
    int          m_cnt, m_lat;
    logic [31:0] m_pend, m_result;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_result <= '0;
        end else if (m_active) begin
            if (m_cnt == m_lat || flush) m_active <= 1'b0;
            else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == m_lat) m_result <= m_pend;
            end
        end else if (start && !flush) begin
            m_active <= 1'b1;
            m_cnt    <= 1;
            m_pend   <= ref_op(funct3, a, b);
            m_lat    <= lat_of(funct3, a, b);
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("busy", busy, m_active);
            chk("done", done, m_active && m_cnt == m_lat);
            chk("result", result, m_result);
        end
    end

    task automatic start_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        funct3 = f; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc  = 0;
        forever begin
            if (busy) bc++;
            if (done) break;
            if (lat >= 100) begin
                chk("done_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_op(input string nm, input logic [2:0] f, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] ex, input int ex_lat);
        int lat, bc;
        chk({nm, "_model"}, ref_op(f, av, bv), ex);
        start_op(f, av, bv);
        wait_done(lat, bc);
        chk({nm, "_res"}, result, ex);
        chk({nm, "_lat"}, lat, ex_lat);
        chk({nm, "_busy"}, bc, ex_lat);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [5];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int lat, bc;
        logic [2:0]  rf;
        logic [31:0] ra, rb, rx;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        check_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
        check_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT);
        check_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
        check_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
        check_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT);
        check_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT);
        check_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        LAT);
        check_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         LAT);
        check_op("div0",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SP);
        check_op("rem0",   3'd6, 32'd5,         32'd0,         32'd5,         LAT_SP);
        check_op("divu0",  3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SP);
        check_op("remu0",  3'd7, 32'd9,         32'd0,         32'd9,         LAT_SP);
        check_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP);
        check_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SP);
        check_op("mulz",   3'd0, 32'd0,         32'h1234_5678, 32'd0,         LAT_SP);
        check_op("mulhuz", 3'd3, 32'hDEAD_BEEF, 32'd0,         32'd0,         LAT_SP);
        check_op("mulpre", 3'd0, 32'd6,         32'd7,         32'd42,        LAT);

        // flush in the middle of a divide
        start_op(3'd4, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_result", result, 32'd42);
        repeat (3) @(negedge clk);
        chk("flush_nodone", done, 0);
        check_op("postflush", 3'd4, 32'd1000, 32'd7, 32'd142, LAT);

        // start together with flush while idle is not accepted
        @(negedge clk);
        funct3 = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("startflush_busy", busy, 0);

        // start while busy is ignored
        start_op(3'd5, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        funct3 = 3'd0; a = 32'd2; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        chk("ignore_res", result, 32'd333);
        chk("ignore_lat", lat, 30);

        // flush in the done cycle does not cancel completion
        start_op(3'd7, 32'd50, 32'd8);
        wait_done(lat, bc);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("doneflush_res", result, 32'd2);

        // reset in the middle of a multiply
        start_op(3'd0, 32'd12345, 32'd678);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        rst_n = 1'b1;
        check_op("postrst", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, LAT);

        for (int i = 0; i < 60; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            rx = ref_op(rf, ra, rb);
            start_op(rf, ra, rb);
            wait_done(lat, bc);
            chk("rnd_res", result, rx);
            chk("rnd_lat", lat, lat_of(rf, ra, rb));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
